rand_spi_source: RTL and testbench
==================================

// Module: rand_spi_source
// PURPOSE
//  Parametrised serial stimulus source emulating an SPI sensor slave for sensor-reader benches and FPGA loopback.
//  Generates one DATA_W-bit word per frame (LFSR, counter, fixed pattern or walking-one) on CHANNELS parallel sdout lines.
//  Shifts the word out MSB-first on edges of an externally driven cs/sclk, oversampled in the clk domain.
// PARAMETERS
//  DATA_W       32            word width, bits per frame (>=8)
//  CHANNELS     1             parallel sdout lanes; lane k carries the frame word rotated left by k
//  POLY         32'h80200003  Galois LFSR taps (x^32+x^22+x^2+x+1)
//  LFSR_SEED    32'hACE10001  LFSR reset state; a zero seed is replaced by 1
//  PATTERN      32'hA5A5_0FF0 word sent in MODE_PAT
//  SYNC_STAGES  2             synchroniser depth for cs and sclk (>=2)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous active-high reset
//  en           in   1          1 = respond to frames; 0 = ignore cs falling edges
//  mode         in   2          0 LFSR, 1 counter, 2 pattern, 3 walking-one; sampled at frame start
//  cs           in   1          frame select from master, active low, asynchronous to clk
//  sclk         in   1          serial clock from master, asynchronous to clk, idle low
//  sdout        out  CHANNELS   serial data, MSB first
//  word         out  DATA_W     word of the current/last frame, lane 0
//  word_cnt     out  16         completed frames, wraps 16'hFFFF->0
//  busy         out  1          high from accepted cs fall to cs rise
//  short_frame  out  1          1-cycle pulse: frame ended with fewer than FRAME_LEN shifts
// BEHAVIOUR
//  Reset: sdout=0, word=LFSR_SEED, word_cnt=0, busy=0, short_frame=0; generator state=LFSR_SEED, counter=0, walk=1.
//  cs/sclk pass through SYNC_STAGES flops, then edge detection. All decisions below use the synced edges.
//  Frame start, on cs fall with en=1:
//   - latch mode; word <= generator output
//   - lane k shift register <= rotl(word,k); sdout = MSBs
//   - bit_cnt=0, busy=1; advance generator once
//  Latency: pin cs fall -> sdout valid after SYNC_STAGES+1 clk cycles.
//  Timing rule: master sclk high and low phases each >= SYNC_STAGES+2 clk cycles.
//  Shift: each sclk fall while busy shifts left, zero-filled, bit_cnt++.
//   - Master samples on sclk rise.
//   - After FRAME_LEN shifts sdout stays 0 until frame end.
//  sclk edges while cs high or busy=0 are ignored; sclk rise before first fall needs no action.
//  Frame end, on cs rise while busy: busy=0, sdout=0.
//   - bit_cnt>=FRAME_LEN: word_cnt++.
//   - Otherwise: short_frame pulse; word_cnt unchanged.
//   - The generator has advanced in both cases.
//  en=0 mid-frame: the frame completes normally; only new starts are blocked.
//  Generators, per frame:
//   - LFSR: Galois step with POLY; a zero state is forced to 1.
//   - Counter: 0,1,2,..., wraps at 2^DATA_W-1.
//   - Pattern: constant PATTERN.
//   - Walk: rotl(walk,1), so bit DATA_W-1 -> bit 0.
//   - All generator states advance every frame regardless of mode.
//  Async rst mid-frame: all state returns to reset values at once; the next frame needs a new cs fall.
// CONFIGURATION
//  RAND_SRC_PARITY_EN defined:
//   - FRAME_LEN=DATA_W+1; an even-parity bit over the lane word follows the LSB.
//   - short_frame threshold becomes DATA_W+1.
//  Undefined: FRAME_LEN=DATA_W, no parity logic.
// STRUCTURE
//  Package rand_src_pkg: MODE_LFSR/MODE_CNT/MODE_PAT/MODE_WALK localparams; default POLY; functions lfsr_next() and rotl().
//  Sub-module rand_src_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs; one instance each for cs and sclk.
//  Top: generator block, CHANNELS-wide generate loop of shift registers, frame control.
// TESTING
//  1. Reset, mode=2, one full 32-sclk frame -> lane 0 receives 32'hA5A50FF0, word_cnt=1, short_frame never 1.
//  2. mode=1, CHANNELS=2, three frames -> lane 0 receives 0,1,2; lane 1 receives 0,2,4; word_cnt=3.
//  3. mode=0, seed 32'hACE10001, two frames -> words equal the golden-model lfsr_next sequence; lane 0 matches word.
//  4. cs low, 10 sclk pulses, cs high -> short_frame pulses once, word_cnt unchanged, next frame's word is the next generator value.
//  5. en=0, cs fall -> busy stays 0, sdout stays 0; en=1 mid-frame -> no start until the next cs fall.
//  6. rst at bit 15 of a frame -> sdout=0, busy=0, word_cnt=0 at once; next frame sends LFSR_SEED (mode=0).
//     With RAND_SRC_PARITY_EN, 33 sclks: bit 33 = ^word.

Source files
------------

// File: rtl/rand_src_pkg.sv
// Shared definitions for the SPI stimulus source: mode codes, frame states, LFSR step and rotate helpers.
// Helpers work on a 64-bit container, so DATA_W must be at most 64.
package rand_src_pkg;

    localparam logic [1:0] MODE_LFSR = 2'd0;
    localparam logic [1:0] MODE_CNT  = 2'd1;
    localparam logic [1:0] MODE_PAT  = 2'd2;
    localparam logic [1:0] MODE_WALK = 2'd3;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = 6;

    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } frame_state_t;

    // Right-shifting Galois step. Zero-extended operands keep it width independent.
    function automatic wide_t lfsr_next(input wide_t state, input wide_t poly);
        wide_t nxt;
        nxt = (state >> 1) ^ (state[0] ? poly : '0);
        if (nxt == '0) begin
            nxt = wide_t'(1);
        end
        return nxt;
    endfunction

    // Rotate the low w bits of x left by k.
    function automatic wide_t rotl(input wide_t x, input int unsigned k, input int unsigned w);
        wide_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[IDX_W'((i + k) % w)] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rand_src_sync.sv
// Multi-flop synchroniser for an asynchronous input with single-cycle rise/fall pulses.
module rand_src_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 0 so an input already low at reset release never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/rand_spi_source.sv
// SPI sensor-slave emulator: one generated word per cs frame, shifted MSB-first on CHANNELS lanes.
// Define RAND_SRC_PARITY_EN to append an even-parity bit after the LSB of every lane.
module rand_spi_source
    import rand_src_pkg::*;
#(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        CHANNELS    = 1,
    parameter logic [DATA_W-1:0]  POLY        = DATA_W'(DEFAULT_POLY),
    parameter logic [DATA_W-1:0]  LFSR_SEED   = DATA_W'(32'hACE1_0001),
    parameter logic [DATA_W-1:0]  PATTERN     = DATA_W'(32'hA5A5_0FF0),
    parameter int unsigned        SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                cs,
    input  logic                sclk,
    output logic [CHANNELS-1:0] sdout,
    output logic [DATA_W-1:0]   word,
    output logic [15:0]         word_cnt,
    output logic                busy,
    output logic                short_frame
);

`ifdef RAND_SRC_PARITY_EN
    localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
    localparam int unsigned FRAME_LEN = DATA_W;
`endif
    localparam int unsigned       CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [DATA_W-1:0] SEED_SAFE = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

    logic cs_rise_c, cs_fall_c, sclk_rise_c, sclk_fall_c;

    rand_src_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (cs),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    rand_src_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Generators: all advance once per accepted frame, mode only picks the output.
    logic [DATA_W-1:0] lfsr_q, cnt_q, walk_q, gen_c;

    always_comb begin
        gen_c = lfsr_q;
        case (mode)
            MODE_CNT:  gen_c = cnt_q;
            MODE_PAT:  gen_c = PATTERN;
            MODE_WALK: gen_c = walk_q;
            default:   gen_c = lfsr_q;
        endcase
    end

    frame_state_t     state_q, state_nxt;
    logic             start_c, shift_c, end_c, full_c;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             sclk_armed_q;

    assign full_c = (bit_cnt_q >= CNT_W'(FRAME_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_SAFE;
            cnt_q  <= '0;
            walk_q <= DATA_W'(1);
        end else if (start_c) begin
            lfsr_q <= DATA_W'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(POLY)));
            cnt_q  <= cnt_q + DATA_W'(1);
            walk_q <= DATA_W'(rotl(MAX_W'(walk_q), 1, DATA_W));
        end
    end

    // Frame control; a shift needs a synced sclk rise seen since the frame started.
    always_comb begin
        state_nxt = state_q;
        start_c   = 1'b0;
        shift_c   = 1'b0;
        end_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c && en) begin
                    start_c   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cs_rise_c) begin
                    end_c     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (sclk_fall_c && sclk_armed_q) begin
                    shift_c = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
            short_frame  <= 1'b0;
            word_cnt     <= '0;
            word         <= LFSR_SEED;
            bit_cnt_q    <= '0;
            sclk_armed_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            busy        <= (state_nxt == ST_BUSY);
            short_frame <= end_c && !full_c;
            if (end_c && full_c) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (start_c) begin
                word <= gen_c;
            end
            if (start_c) begin
                bit_cnt_q <= '0;
            end else if (shift_c && !full_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (start_c) begin
                sclk_armed_q <= 1'b0;
            end else if (sclk_rise_c) begin
                sclk_armed_q <= 1'b1;
            end
        end
    end

    // Lane k carries the frame word rotated left by k; zero fill keeps sdout low after the last bit.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [FRAME_LEN-1:0] sh_q;
        logic [DATA_W-1:0]    lane_c;

        assign lane_c = DATA_W'(rotl(MAX_W'(gen_c), k, DATA_W));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh_q <= '0;
            end else if (start_c) begin
`ifdef RAND_SRC_PARITY_EN
                sh_q <= {lane_c, ^lane_c};
`else
                sh_q <= lane_c;
`endif
            end else if (end_c) begin
                sh_q <= '0;
            end else if (shift_c) begin
                sh_q <= {sh_q[FRAME_LEN-2:0], 1'b0};
            end
        end

        assign sdout[k] = sh_q[FRAME_LEN-1];
    end

endmodule

// File: tb/tb_rand_spi_source.sv
// Directed bench for rand_spi_source with a frame-level reference model (honours RAND_SRC_PARITY_EN).
module tb_rand_spi_source;

    localparam int unsigned DW = 32;
    localparam int unsigned CH = 2;
`ifdef RAND_SRC_PARITY_EN
    localparam int unsigned FL = DW + 1;
`else
    localparam int unsigned FL = DW;
`endif
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] PAT  = 32'hA5A5_0FF0;

    logic          clk = 1'b0;
    logic          rst, en, cs, sclk;
    logic [1:0]    mode;
    logic [CH-1:0] sdout;
    logic [31:0]   word;
    logic [15:0]   word_cnt;
    logic          busy, short_frame;

    int n_checks   = 0;
    int n_errors   = 0;
    int short_seen = 0;

    logic          chk_en = 1'b0;
    logic          exp_busy;
    logic [CH-1:0] exp_sdout;

    logic [31:0] m_lfsr, m_cnt, m_walk, m_word;
    logic [15:0] m_wcnt;
    int          m_short = 0;

    logic [31:0] rx0, rx1;

    rand_spi_source #(
        .DATA_W   (DW),
        .CHANNELS (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .cs          (cs),
        .sclk        (sclk),
        .sdout       (sdout),
        .word        (word),
        .word_cnt    (word_cnt),
        .busy        (busy),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

    function automatic logic [31:0] gen(input logic [1:0] md);
        case (md)
            2'd0:    return m_lfsr;
            2'd1:    return m_cnt;
            2'd2:    return PAT;
            default: return m_walk;
        endcase
    endfunction

    // Bit image of one lane as it leaves the pin: word MSB first, then parity if enabled.
    function automatic logic [32:0] img(input logic [31:0] w);
`ifdef RAND_SRC_PARITY_EN
        return {w, ^w};
`else
        return {w, 1'b0};
`endif
    endfunction

    function automatic logic bit_at(input logic [32:0] im, input int i);
        if (i < int'(FL)) return im[32-i];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_lfsr   = SEED;
        m_cnt    = 32'd0;
        m_walk   = 32'd1;
        m_word   = SEED;
        m_wcnt   = 16'd0;
        exp_busy = 1'b0;
        exp_sdout = '0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(3);
    endtask

    // Per-cycle comparison against the model while the bench marks outputs as settled.
    always @(negedge clk) begin
        if (short_frame === 1'b1) short_seen++;
        if (chk_en) begin
            check("busy", 64'(busy), 64'(exp_busy));
            check("word", 64'(word), 64'(m_word));
            check("word_cnt", 64'(word_cnt), 64'(m_wcnt));
            check("sdout", 64'(sdout), 64'(exp_sdout));
            check("short_idle", 64'(short_frame), 64'd0);
        end
    end

    task automatic run_frame(input int nbits, input logic en_mid, input int rst_at,
                             output logic [31:0] r0, output logic [31:0] r1);
        logic        started;
        logic [32:0] l0, l1;
        r0 = '0;
        r1 = '0;
        chk_en = 1'b0;
        started = en;
        l0 = '0;
        l1 = '0;
        if (started) begin
            m_word = gen(mode);
            l0 = img(m_word);
            l1 = img(rotl32(m_word, 1));
            m_lfsr = lfsr_step(m_lfsr);
            m_cnt  = m_cnt + 32'd1;
            m_walk = rotl32(m_walk, 1);
            exp_busy = 1'b1;
        end
        cs = 1'b0;
        cyc(5);
        for (int i = 0; i < nbits; i++) begin
            if (en_mid && i == nbits / 2) en = 1'b1;
            sclk = 1'b1;
            cyc(4);
            exp_sdout = {bit_at(l1, i), bit_at(l0, i)};
            chk_en = 1'b1;
            cyc(2);
            chk_en = 1'b0;
            if (i < 32) begin
                r0[31-i] = sdout[0];
                r1[31-i] = sdout[1];
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_sdout", 64'(sdout), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_word_cnt", 64'(word_cnt), 64'd0);
                cyc(1);
                rst = 1'b0;
                model_reset();
                started = 1'b0;
                break;
            end
            sclk = 1'b0;
            cyc(5);
        end
        sclk = 1'b0;
        cyc(5);
        cs = 1'b1;
        cyc(4);
        if (started) begin
            if (nbits >= int'(FL)) m_wcnt = m_wcnt + 16'd1;
            else m_short++;
        end
        exp_busy = 1'b0;
        exp_sdout = '0;
        chk_en = 1'b1;
        cyc(2);
        chk_en = 1'b0;
        check("short_count", 64'(short_seen), 64'(m_short));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        cs = 1'b1;
        sclk = 1'b0;
        mode = 2'd2;
        model_reset();
        cyc(3);
        rst = 1'b0;
        cyc(3);
        check("reset_sdout", 64'(sdout), 64'd0);
        check("reset_word", 64'(word), 64'(SEED));
        check("reset_word_cnt", 64'(word_cnt), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_short", 64'(short_frame), 64'd0);

        // Fixed pattern, full frame.
        run_frame(FL, 1'b0, -1, rx0, rx1);
        check("pat_rx", 64'(rx0), 64'(32'hA5A5_0FF0));
        check("pat_cnt", 64'(word_cnt), 64'd1);
        check("pat_short", 64'(short_seen), 64'd0);

        // Counter on two lanes after a fresh reset.
        do_reset();
        mode = 2'd1;
        for (int f = 0; f < 3; f++) begin
            run_frame(FL, 1'b0, -1, rx0, rx1);
            check("cnt_lane0", 64'(rx0), 64'(f));
            check("cnt_lane1", 64'(rx1), 64'(2 * f));
        end
        check("cnt_word_cnt", 64'(word_cnt), 64'd3);

        // LFSR frames against the model sequence.
        mode = 2'd0;
        for (int f = 0; f < 2; f++) begin
            run_frame(FL, 1'b0, -1, rx0, rx1);
            check("lfsr_rx", 64'(rx0), 64'(m_word));
        end

        // Short frame, then the next generator value.
        run_frame(10, 1'b0, -1, rx0, rx1);
        check("short_word_cnt", 64'(word_cnt), 64'd5);
        check("short_pulses", 64'(short_seen), 64'd1);
        run_frame(FL, 1'b0, -1, rx0, rx1);
        check("after_short_rx", 64'(rx0), 64'(m_word));

        // en low at cs fall blocks the frame even if en rises mid-frame.
        en = 1'b0;
        run_frame(8, 1'b1, -1, rx0, rx1);
        check("en_off_word_cnt", 64'(word_cnt), 64'd6);
        mode = 2'd3;
        run_frame(FL, 1'b0, -1, rx0, rx1);
        check("walk_rx", 64'(rx0), 64'(m_word));

        // Reset mid-frame, then the LFSR restarts from the seed.
        mode = 2'd0;
        run_frame(FL, 1'b0, 15, rx0, rx1);
        run_frame(FL, 1'b0, -1, rx0, rx1);
        check("seed_rx", 64'(rx0), 64'(32'hACE1_0001));
        run_frame(FL, 1'b0, -1, rx0, rx1);
        check("lfsr1_rx", 64'(rx0), 64'(32'hD650_8003));
        check("post_rst_cnt", 64'(word_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
